// File: rtl/nanorv32_ahb_master_bridge_pkg.sv
// nanorv32_ahb_master_bridge_pkg: AHB-Lite encodings and bridge state type
package nanorv32_ahb_master_bridge_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;
endpackage

// File: rtl/nanorv32_ahb_bytesel_dec.sv
// nanorv32_ahb_bytesel_dec: CPU lane enables -> legality, hsize and low address bits
module nanorv32_ahb_bytesel_dec
    import nanorv32_ahb_master_bridge_pkg::*;
(
    input  logic [3:0] bytesel,
    output logic       legal,
    output logic [2:0] hsize,
    output logic [1:0] addr_lo
);
    always_comb begin
        legal   = 1'b1;
        hsize   = HSIZE_WORD;
        addr_lo = 2'b00;
        case (bytesel)
            4'b1111: ;
            4'b0011: hsize = HSIZE_HALF;
            4'b1100: begin hsize = HSIZE_HALF; addr_lo = 2'b10; end
            4'b0001: hsize = HSIZE_BYTE;
            4'b0010: begin hsize = HSIZE_BYTE; addr_lo = 2'b01; end
            4'b0100: begin hsize = HSIZE_BYTE; addr_lo = 2'b10; end
            4'b1000: begin hsize = HSIZE_BYTE; addr_lo = 2'b11; end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/nanorv32_ahb_master_bridge.sv
// nanorv32_ahb_master_bridge: CPU req/ack data port -> single-transfer AHB-Lite master
module nanorv32_ahb_master_bridge
    import nanorv32_ahb_master_bridge_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_bytesel,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);
    state_t      state, state_n;
    logic        legal, hwrite_n, err_n;
    logic [2:0]  dec_size, hsize_n;
    logic [1:0]  dec_lo, htrans_n;
    logic [31:0] haddr_n, hwdata_n, rdata_n, wdata_q, wdata_n;
    logic        unused_addr_lo;

    assign unused_addr_lo = ^cpu_addr[1:0];
    assign hburst    = HBURST_SINGLE;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;

    nanorv32_ahb_bytesel_dec u_dec (
        .bytesel (cpu_bytesel),
        .legal   (legal),
        .hsize   (dec_size),
        .addr_lo (dec_lo)
    );

    always_comb begin
        state_n  = state;
        haddr_n  = haddr;
        htrans_n = htrans;
        hwrite_n = hwrite;
        hsize_n  = hsize;
        hwdata_n = hwdata;
        wdata_n  = wdata_q;
        rdata_n  = cpu_rdata;
        err_n    = 1'b0;
        case (state)
            ST_IDLE: if (cpu_req) begin
                if (legal) begin
                    haddr_n  = {cpu_addr[31:2], dec_lo};
                    hsize_n  = dec_size;
                    hwrite_n = cpu_wr;
                    htrans_n = HTRANS_NONSEQ;
                    wdata_n  = cpu_wdata;
                    state_n  = ST_ADDR;
                end else begin
                    err_n   = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_ADDR: if (hready) begin
                htrans_n = HTRANS_IDLE;
                hwdata_n = hwrite ? wdata_q : '0;
                state_n  = ST_DATA;
            end
            // an ERROR first cycle arrives with hready=0 and is simply another wait
            ST_DATA: if (hready) begin
                rdata_n  = hwrite ? cpu_rdata : hrdata;
                err_n    = hresp;
                hwdata_n = '0;
                state_n  = ST_RESP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_IDLE;
            haddr     <= '0;
            htrans    <= HTRANS_IDLE;
            hwrite    <= 1'b0;
            hsize     <= HSIZE_WORD;
            hwdata    <= '0;
            wdata_q   <= '0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
        end else begin
            state     <= state_n;
            haddr     <= haddr_n;
            htrans    <= htrans_n;
            hwrite    <= hwrite_n;
            hsize     <= hsize_n;
            hwdata    <= hwdata_n;
            wdata_q   <= wdata_n;
            cpu_rdata <= rdata_n;
            cpu_ack   <= state_n == ST_RESP;
            cpu_err   <= err_n;
        end
    end
endmodule

// File: tb/tb_nanorv32_ahb_master_bridge.sv
// tb_nanorv32_ahb_master_bridge: directed checks of the CPU->AHB bridge
module tb_nanorv32_ahb_master_bridge;
    logic        clk_in = 1'b0;
    logic        rst, cpu_req, cpu_wr, cpu_ack, cpu_err, hwrite, hmastlock, hready, hresp;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, haddr, hwdata, hrdata;
    logic [3:0]  cpu_bytesel, hprot;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;

    int          n_tests = 0, n_fail = 0;
    int          lat, n_nonseq;
    logic [1:0]  t1;
    logic [2:0]  s1;
    logic        w1, er_r, ack_after;
    logic [31:0] a1, wd2, rd_r;

    nanorv32_ahb_master_bridge dut (
        .clk_in(clk_in), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_bytesel(cpu_bytesel), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk_in = ~clk_in;

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle c counts from the edge that samples the request; data-phase waits occupy cycles 2..1+nw
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [3:0] bs,
                        input logic [31:0] wd, input int nw, input logic [31:0] rd, input logic rsp);
        lat = 0;
        n_nonseq = 0;
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_bytesel = bs; cpu_wdata = wd;
        hrdata = rd; hready = 1'b1; hresp = 1'b0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk_in);
            if (htrans == 2'b10) n_nonseq++;
            if (c == 1) begin t1 = htrans; a1 = haddr; s1 = hsize; w1 = hwrite; end
            if (c == 2) wd2 = hwdata;
            if (cpu_ack) begin lat = c; rd_r = cpu_rdata; er_r = cpu_err; cpu_req = 1'b0; end
            hready = !(c >= 2 && c < 2 + nw);
            hresp  = rsp && c >= 2;
        end
        cpu_req = 1'b0; hready = 1'b1; hresp = 1'b0;
        @(negedge clk_in);
        ack_after = cpu_ack;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_bytesel = 4'hF;
        cpu_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rst_htrans", 32'(htrans), 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwrite", 32'(hwrite), 32'h0);
        check("rst_hsize", 32'(hsize), 32'h2);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_ack", 32'(cpu_ack), 32'h0);
        check("rst_err", 32'(cpu_err), 32'h0);
        check("const_hburst", 32'(hburst), 32'h0);
        check("const_hprot", 32'(hprot), 32'h3);
        check("const_hmastlock", 32'(hmastlock), 32'h0);
        rst = 1'b0;
        @(negedge clk_in);

        xfer(1'b1, 32'h4000_0010, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        check("w_htrans", 32'(t1), 32'h2);
        check("w_haddr", a1, 32'h4000_0010);
        check("w_hsize", 32'(s1), 32'h2);
        check("w_hwrite", 32'(w1), 32'h1);
        check("w_hwdata", wd2, 32'hDEAD_BEEF);
        check("w_lat", 32'(lat), 32'd3);
        check("w_err", 32'(er_r), 32'h0);
        check("w_ack_pulse", 32'(ack_after), 32'h0);

        xfer(1'b0, 32'h4000_0020, 4'b1111, 32'h0, 2, 32'h1234_5678, 1'b0);
        check("r_hwrite", 32'(w1), 32'h0);
        check("r_hwdata", wd2, 32'h0);
        check("r_lat", 32'(lat), 32'd5);
        check("r_rdata", rd_r, 32'h1234_5678);
        check("r_err", 32'(er_r), 32'h0);

        xfer(1'b1, 32'h4000_0030, 4'b1000, 32'hAB00_0000, 0, 32'hFFFF_FFFF, 1'b0);
        check("b_haddr", a1, 32'h4000_0033);
        check("b_hsize", 32'(s1), 32'h0);
        check("b_rdata_kept", rd_r, 32'h1234_5678);
        check("b_lat", 32'(lat), 32'd3);

        xfer(1'b1, 32'h4000_0030, 4'b1100, 32'hCDEF_0000, 0, 32'h0, 1'b0);
        check("h_haddr", a1, 32'h4000_0032);
        check("h_hsize", 32'(s1), 32'h1);
        check("h_hwdata", wd2, 32'hCDEF_0000);

        xfer(1'b1, 32'h4000_0001, 4'b0010, 32'h0000_5500, 0, 32'h0, 1'b0);
        check("b1_haddr", a1, 32'h4000_0001);
        check("b1_hsize", 32'(s1), 32'h0);

        xfer(1'b0, 32'h4000_0050, 4'b1111, 32'h0, 1, 32'hBAD0_BAD0, 1'b1);
        check("e_lat", 32'(lat), 32'd4);
        check("e_err", 32'(er_r), 32'h1);
        check("e_one_nonseq", 32'(n_nonseq), 32'd1);

        xfer(1'b0, 32'h4000_0060, 4'b0011, 32'h0, 0, 32'h0000_A5A5, 1'b0);
        check("e2_lat", 32'(lat), 32'd3);
        check("e2_err", 32'(er_r), 32'h0);
        check("e2_rdata", rd_r, 32'h0000_A5A5);
        check("e2_hsize", 32'(s1), 32'h1);

        xfer(1'b1, 32'h4000_0070, 4'b0110, 32'h1111_1111, 0, 32'h0, 1'b0);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_err", 32'(er_r), 32'h1);
        check("ill_no_nonseq", 32'(n_nonseq), 32'd0);
        check("ill_ack_pulse", 32'(ack_after), 32'h0);

        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h4000_0080; cpu_bytesel = 4'hF; hready = 1'b1;
        @(negedge clk_in);
        check("rd_start_nonseq", 32'(htrans), 32'h2);
        @(negedge clk_in);
        hready = 1'b0; rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk_in);
        check("rs_htrans", 32'(htrans), 32'h0);
        check("rs_haddr", haddr, 32'h0);
        check("rs_hsize", 32'(hsize), 32'h2);
        check("rs_ack", 32'(cpu_ack), 32'h0);
        check("rs_rdata", cpu_rdata, 32'h0);
        rst = 1'b0; hready = 1'b1;
        @(negedge clk_in);
        check("rs_no_ack", 32'(cpu_ack), 32'h0);
        xfer(1'b1, 32'h4000_0090, 4'b0001, 32'h0000_0077, 0, 32'h0, 1'b0);
        check("rs2_haddr", a1, 32'h4000_0090);
        check("rs2_hsize", 32'(s1), 32'h0);
        check("rs2_lat", 32'(lat), 32'd3);
        check("rs2_err", 32'(er_r), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
